// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between the CPU (port 0)
// and the debug/loader port (port 1), with bounded burst locking and read-return routing.
module dmem_arbiter #(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 64,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic              p0_lock,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic              p1_lock,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    state_t           state, state_nxt;
    logic             last_win, last_win_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             rd_pend, rd_owner;
    logic             gnt0, gnt1, done, win, win_we, win_lock;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            last_win <= 1'b1;
            rd_pend  <= 1'b0;
            rd_owner <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            last_win <= last_win_nxt;
            rd_pend  <= done & ~win_we;
            rd_owner <= win;
        end
    end

    // Grants are suppressed while reset is asserted so the RAM sees no access.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (p0_req && (!p1_req || last_win)) gnt0 = 1'b1;
                    else if (p1_req)                     gnt1 = 1'b1;
                end
                OWN0:    gnt0 = p0_req;
                OWN1:    gnt1 = p1_req;
                default: ;
            endcase
        end
    end

    assign done     = gnt0 | gnt1;
    assign win      = gnt1;
    assign win_we   = gnt1 ? p1_we   : p0_we;
    assign win_lock = gnt1 ? p1_lock : p0_lock;

    // In OWNx a cycle without a beat means the owner dropped req and gives up the lock.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        last_win_nxt = done ? win : last_win;
        cnt_inc      = cnt + CNT_ONE;
        case (state)
            IDLE: begin
                if (done && win_lock && (CNT_ONE != CNT_MAX)) begin
                    state_nxt = win ? OWN1 : OWN0;
                    cnt_nxt   = CNT_ONE;
                end
            end
            OWN0, OWN1: begin
                if (!done || !win_lock || (cnt_inc == CNT_MAX)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        p0_gnt    = gnt0;
        p1_gnt    = gnt1;
        mem_en    = done;
        mem_we    = done & win_we;
        mem_addr  = gnt1 ? p1_addr  : (gnt0 ? p0_addr  : '0);
        mem_wdata = gnt1 ? p1_wdata : (gnt0 ? p0_wdata : '0);
        p0_rvalid = rd_pend & ~rd_owner;
        p1_rvalid = rd_pend &  rd_owner;
        p0_rdata  = p0_rvalid ? mem_rdata : '0;
        p1_rdata  = p1_rvalid ? mem_rdata : '0;
        busy      = (state != IDLE) | rd_pend;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: behavioural RAM, ownership/round-robin reference model,
// directed scenarios followed by randomized traffic.
module tb_dmem_arbiter;
    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 64;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        req  = '0;
    logic [1:0]        we   = '0;
    logic [1:0]        lock = '0;
    logic [ADDR_W-1:0] addr  [2];
    logic [DATA_W-1:0] wdata [2];
    logic              gnt0, gnt1, rv0, rv1, mem_en, mem_we, busy;
    logic [DATA_W-1:0] rd0, rd1, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    logic [DATA_W-1:0] ram [128];
    logic [DATA_W-1:0] ram_q;

    int tests = 0;
    int fails = 0;
    int hist[$];

    // Reference model state: owning port (-1 = none), beats in the current burst, last winner,
    // and the read result expected on the following cycle.
    int                m_owner, m_beats, m_last, m_rd_port;
    bit                m_rd_pend;
    logic [DATA_W-1:0] m_rd_data;
    logic [DATA_W-1:0] ref_mem [128];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        ram_q         <= ram[mem_addr];
        end
    end
    assign mem_rdata = ram_q;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst),
        .p0_req(req[0]), .p0_we(we[0]), .p0_lock(lock[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
        .p0_gnt(gnt0), .p0_rvalid(rv0), .p0_rdata(rd0),
        .p1_req(req[1]), .p1_we(we[1]), .p1_lock(lock[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
        .p1_gnt(gnt1), .p1_rvalid(rv1), .p1_rdata(rd1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner   = -1;
        m_beats   = 0;
        m_last    = 1;
        m_rd_pend = 1'b0;
        m_rd_port = 0;
        m_rd_data = '0;
    endtask

    function automatic int predict();
        if (!rst)                return -1;
        if (m_owner >= 0)        return req[m_owner] ? m_owner : -1;
        if (req[0] && req[1])    return 1 - m_last;
        if (req[0])              return 0;
        if (req[1])              return 1;
        return -1;
    endfunction

    task automatic model_update(input int g);
        if (!rst) begin
            model_reset();
            return;
        end
        if (g < 0) begin
            m_rd_pend = 1'b0;
            m_owner   = -1;
        end else begin
            m_rd_pend = !we[g];
            m_rd_port = g;
            m_rd_data = ref_mem[addr[g]];
            if (we[g]) ref_mem[addr[g]] = wdata[g];
            m_last = g;
            if (m_owner < 0) begin
                if (lock[g]) begin
                    m_owner = g;
                    m_beats = 1;
                end
            end else begin
                m_beats++;
            end
            if (m_owner >= 0 && (!lock[g] || m_beats >= MAX_BURST)) m_owner = -1;
        end
    endtask

    // One clock cycle: inputs are already applied after a falling edge.
    task automatic cycle(output int g);
        logic e_rv0, e_rv1;
        #1;
        g     = predict();
        e_rv0 = m_rd_pend && (m_rd_port == 0);
        e_rv1 = m_rd_pend && (m_rd_port == 1);
        hist.push_back(gnt0 ? 0 : (gnt1 ? 1 : -1));
        check("gnt0",      gnt0,      g == 0);
        check("gnt1",      gnt1,      g == 1);
        check("mem_en",    mem_en,    g >= 0);
        check("mem_we",    mem_we,    (g >= 0) ? we[g] : 1'b0);
        check("mem_addr",  mem_addr,  (g >= 0) ? addr[g] : '0);
        check("mem_wdata", mem_wdata, (g >= 0) ? wdata[g] : '0);
        check("rvalid0",   rv0,       e_rv0);
        check("rvalid1",   rv1,       e_rv1);
        check("rdata0",    rd0,       e_rv0 ? m_rd_data : '0);
        check("rdata1",    rd1,       e_rv1 ? m_rd_data : '0);
        check("busy",      busy,      (m_owner >= 0) || m_rd_pend);
        @(posedge clk);
        model_update(g);
        @(negedge clk);
    endtask

    task automatic drive(input int p, input bit r, input bit w, input bit l,
                         input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req[p]   = r;
        we[p]    = w;
        lock[p]  = l;
        addr[p]  = a;
        wdata[p] = d;
    endtask

    initial begin
        int g;
        int idx;
        int exp_tie[4]   = '{0, 1, 0, 1};
        int exp_burst[7] = '{1, 1, 1, 1, 0, 1, 1};

        addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
        model_reset();

        // Reset with both ports requesting: everything must stay quiet.
        req = 2'b11;
        @(negedge clk);
        cycle(g);
        cycle(g);
        req = 2'b00;
        rst = 1'b1;

        // Initialise addresses 0..15 from port 1, with RAM[5] = 42.
        for (int a = 0; a < 16; a++) begin
            drive(1, 1, 1, 0, ADDR_W'(a), (a == 5) ? 64'd42 : 64'd100 + 64'(a) * 3);
            cycle(g);
        end
        drive(1, 0, 0, 0, '0, '0);

        // Tie between two continuous readers: port 0 wins first, then alternation.
        hist.delete();
        drive(0, 1, 0, 0, 7'd1, '0);
        drive(1, 1, 0, 0, 7'd2, '0);
        for (int i = 0; i < 4; i++) cycle(g);
        for (int i = 0; i < 4; i++) check("tie_order", hist[i], exp_tie[i]);
        drive(0, 0, 0, 0, '0, '0);
        drive(1, 0, 0, 0, '0, '0);
        cycle(g);

        // Single read of address 5.
        drive(0, 1, 0, 0, 7'd5, '0);
        #1;
        check("single_gnt",  gnt0, 1'b1);
        check("single_addr", mem_addr, 64'd5);
        cycle(g);
        drive(0, 0, 0, 0, '0, '0);
        #1;
        check("single_rvalid",  rv0, 1'b1);
        check("single_rdata",   rd0, 64'd42);
        check("single_rvalid1", rv1, 1'b0);
        cycle(g);

        // Forced release: port 1 locked writes to 10..15 against a continuous port 0 reader.
        hist.delete();
        idx = 0;
        drive(0, 1, 0, 0, 7'd0, '0);
        for (int n = 0; n < 20 && idx < 6; n++) begin
            drive(1, 1, 1, 1, ADDR_W'(10 + idx), 64'd1000 + 64'(idx));
            cycle(g);
            if (g == 1) idx++;
        end
        check("burst_done", idx, 6);
        for (int i = 0; i < 7; i++)
            check("burst_order", (i < hist.size()) ? hist[i] : -2, exp_burst[i]);
        drive(0, 0, 0, 0, '0, '0);
        drive(1, 0, 0, 0, '0, '0);
        cycle(g);
        for (int i = 0; i <= 6; i++) begin
            drive(0, i < 6, 0, 0, ADDR_W'(10 + i), '0);
            #1;
            if (i > 0) check("burst_ram", rd0, 64'd1000 + 64'(i - 1));
            cycle(g);
        end

        // Lock abandon: two locked beats from port 0, then it drops req while port 1 waits.
        drive(0, 1, 1, 1, 7'd20, 64'h20);
        cycle(g);
        drive(0, 1, 1, 1, 7'd21, 64'h21);
        cycle(g);
        drive(0, 0, 0, 0, '0, '0);
        drive(1, 1, 0, 0, 7'd3, '0);
        #1;
        check("abandon_hold", gnt1, 1'b0);
        cycle(g);
        #1;
        check("abandon_gnt", gnt1, 1'b1);
        cycle(g);
        drive(1, 0, 0, 0, '0, '0);
        #1;
        check("abandon_busy_rd", busy, 1'b1);
        cycle(g);
        #1;
        check("abandon_idle", busy, 1'b0);
        cycle(g);

        // Reset while a read is outstanding.
        drive(0, 1, 0, 0, 7'd5, '0);
        cycle(g);
        rst = 1'b0;
        req = 2'b11;
        model_reset();
        #1;
        check("rst_rvalid", rv0, 1'b0);
        check("rst_busy",   busy, 1'b0);
        check("rst_gnt",    {gnt0, gnt1}, 2'b00);
        check("rst_mem_en", mem_en, 1'b0);
        cycle(g);
        rst = 1'b1;
        drive(0, 1, 0, 0, 7'd1, '0);
        drive(1, 1, 0, 0, 7'd2, '0);
        hist.delete();
        cycle(g);
        check("rst_first_tie", hist[0], 0);
        cycle(g);
        drive(0, 0, 0, 0, '0, '0);
        drive(1, 0, 0, 0, '0, '0);
        cycle(g);

        // Top address passes through unmodified.
        drive(1, 1, 1, 0, 7'h7F, 64'hDEAD);
        #1;
        check("top_addr", mem_addr, 64'h7F);
        cycle(g);
        drive(1, 0, 0, 0, '0, '0);
        drive(0, 1, 0, 0, 7'h7F, '0);
        #1;
        check("top_no_wr_rvalid", rv1, 1'b0);
        cycle(g);
        drive(0, 0, 0, 0, '0, '0);
        #1;
        check("top_rdata", rd0, 64'hDEAD);
        cycle(g);

        // Randomized traffic over the initialised addresses.
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++)
                drive(p, 1'($urandom), 1'($urandom), 1'($urandom),
                      ($urandom_range(7) == 0) ? 7'h7F : ADDR_W'($urandom_range(15)),
                      {$urandom, $urandom});
            cycle(g);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
